// File: rtl/alu_exec.sv
// rtl/alu_exec.sv - registered ALU with valid/ready handshake and bit-serial shifter
`timescale 1ns/1ps

module alu_exec #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_ctrl,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            busy
);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLL  = 4'b0101;
    localparam logic [3:0] OP_SRL  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1001;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        SH_LEFT  = 2'b00,
        SH_LOGIC = 2'b01,
        SH_ARITH = 2'b10
    } shift_t;

    state_t          state_q,     state_d;
    shift_t          shop_q,      shop_d;
    logic [XLEN-1:0] shreg_q,     shreg_d;
    logic [4:0]      cnt_q,       cnt_d;
    logic            fill_q,      fill_d;
    logic [XLEN-1:0] result_q,    result_d;
    logic            zero_q,      zero_d;
    logic            out_valid_q, out_valid_d;

    logic            accept;
    logic            is_shift;
    logic [4:0]      shamt;
    logic [XLEN-1:0] comb_res;
    logic [XLEN-1:0] step_res;
    logic            slt_bit;
    logic            sltu_bit;

    assign shamt     = op_b[4:0];
    assign in_ready  = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign busy      = (state_q == ST_SHIFT);

    assign slt_bit   = ($signed(op_a) < $signed(op_b));
    assign sltu_bit  = (op_a < op_b);

    // Single-cycle results; shifts only reach here with shamt == 0 (pass op_a).
    always_comb begin
        comb_res = op_a + op_b;
        is_shift = 1'b0;
        case (alu_ctrl)
            OP_ADD:  comb_res = op_a + op_b;
            OP_SUB:  comb_res = op_a - op_b;
            OP_AND:  comb_res = op_a & op_b;
            OP_OR:   comb_res = op_a | op_b;
            OP_XOR:  comb_res = op_a ^ op_b;
            OP_SLL,
            OP_SRL,
            OP_SRA: begin
                comb_res = op_a;
                is_shift = 1'b1;
            end
            OP_SLT:  comb_res = {{(XLEN-1){1'b0}}, slt_bit};
            OP_SLTU: comb_res = {{(XLEN-1){1'b0}}, sltu_bit};
            default: comb_res = op_a + op_b;
        endcase
    end

    // One-bit shift step of the serial shift register; SRA fills with the captured sign.
    always_comb begin
        step_res = {shreg_q[XLEN-2:0], 1'b0};
        case (shop_q)
            SH_LEFT:  step_res = {shreg_q[XLEN-2:0], 1'b0};
            SH_LOGIC: step_res = {1'b0, shreg_q[XLEN-1:1]};
            SH_ARITH: step_res = {fill_q, shreg_q[XLEN-1:1]};
            default:  step_res = {shreg_q[XLEN-2:0], 1'b0};
        endcase
    end

    // Next-state and datapath updates: accept in IDLE, count down shift steps in SHIFT.
    always_comb begin
        state_d     = state_q;
        shop_d      = shop_q;
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        fill_d      = fill_q;
        result_d    = result_q;
        zero_d      = zero_q;
        out_valid_d = out_valid_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (is_shift && (shamt != 5'd0)) begin
                        state_d = ST_SHIFT;
                        shreg_d = op_a;
                        cnt_d   = shamt;
                        fill_d  = op_a[XLEN-1];
                        case (alu_ctrl)
                            OP_SLL:  shop_d = SH_LEFT;
                            OP_SRL:  shop_d = SH_LOGIC;
                            default: shop_d = SH_ARITH;
                        endcase
                    end else begin
                        result_d    = comb_res;
                        zero_d      = (comb_res == '0);
                        out_valid_d = 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                shreg_d = step_res;
                cnt_d   = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    state_d     = ST_IDLE;
                    result_d    = step_res;
                    zero_d      = (step_res == '0);
                    out_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            shop_q      <= SH_LEFT;
            shreg_q     <= '0;
            cnt_q       <= '0;
            fill_q      <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shop_q      <= shop_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            fill_q      <= fill_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule
